ifu_fetch: RTL and testbench
============================

Name: ifu_fetch

Overview:
- Instruction fetch unit: owns the PC and issues single-word reads to instruction memory (the random-generating memory model or a real memory).
- Buffers returned words with their addresses and presents them to decode over a valid/ready handshake.
- Supports redirect (jump/skip/interrupt vector) from execute, and a halt request that quiesces fetching.
- Sits between instruction memory (upstream) and decode (downstream).

Parameters:
- ADDR_WIDTH, 12 (= `ADDR_WIDTH): address and PC width.
- DATA_WIDTH, 12 (= `DATA_WIDTH): instruction word width.
- RESET_PC, 'o0200: PC loaded at reset.
- BUF_DEPTH, 2: instruction buffer entries; must be ≥2 for a sustained rate of 1 instruction/cycle.

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst_n  in  1  synchronous reset, active-low.
- ifu_rd_req  out  1  memory read request, one word per asserted cycle.
- ifu_rd_addr  out  ADDR_WIDTH  read address; valid while ifu_rd_req=1.
- ifu_rd_data  in  DATA_WIDTH  read data; valid in the cycle after a request.
- instr_valid  out  1  buffer head is valid.
- instr_data  out  DATA_WIDTH  head instruction word.
- instr_pc  out  ADDR_WIDTH  address the head word was fetched from.
- instr_ready  in  1  decode accepts the head this cycle.
- redirect_valid  in  1  one-cycle pulse: discard all fetched and in-flight work and restart at redirect_pc.
- redirect_pc  in  ADDR_WIDTH  redirect target.
- halt_req  in  1  level: stop issuing new reads.
- ifu_halted  out  1  high in HALTED state.

Behaviour:
- Reset (rst_n=0 at posedge): pc=RESET_PC; buffer empty; pending=0; state=RUN. Next cycle: ifu_rd_req=0, ifu_rd_addr=0, instr_valid=0, instr_data=0, instr_pc=0, ifu_halted=0. Reset mid-operation drops buffer contents and any in-flight read.
- Memory timing: the read is registered. A request in cycle N returns data in cycle N+1, which the IFU captures at the posedge ending N+1. At most one response per cycle.
- Issue rule: ifu_rd_req=1 in a cycle iff all of the following hold:
  - state=RUN
  - halt_req=0
  - redirect_valid=0
  - count + pending − pop < BUF_DEPTH, where pop = instr_valid & instr_ready.
  When issuing: ifu_rd_addr=pc; at the posedge, pc ← pc+1 mod 2^ADDR_WIDTH ('o7777 → 'o0000), pend_addr ← pc, pending ← 1. When not issuing: pending ← 0.
- Response: if pending=1 and the cycle has no redirect, push {ifu_rd_data, pend_addr} into the buffer.
- Push and pop in the same cycle are both legal; count is unchanged.
- Buffer is FIFO: instr_valid = (count≠0); instr_data/instr_pc come from the head. Head stays stable while instr_valid & !instr_ready.
- Redirect (highest priority, every state):
  - Buffer flushed: count=0 next cycle, and a same-cycle pop is treated as completed.
  - Any pending response is discarded.
  - pc ← redirect_pc; no request in the redirect cycle; state ← RUN, even if halt_req is still high (halt is re-evaluated from the next cycle).
  - The first request to redirect_pc goes out in the next cycle if the issue rule holds.
- FSM:
  - RUN → DRAIN when halt_req=1 and pending=1.
  - RUN → HALTED when halt_req=1 and pending=0.
  - DRAIN → HALTED after the last response is pushed.
  - HALTED → RUN on halt_req=0 or redirect.
  - No requests are issued in DRAIN or HALTED. The buffer still drains to decode in all states. ifu_halted=1 only in HALTED.
- pc and pend_addr never change except on issue, redirect, or reset. ifu_rd_data is ignored when pending=0.

Decomposition:
- Package ifu_pkg holds:
  - address and word typedefs sized from `ADDR_WIDTH/`DATA_WIDTH
  - RESET_PC
  - the state enum {RUN, DRAIN, HALTED}
  - a struct type {word, pc} for buffer entries
- One sub-module: ifu_instr_fifo. Parameterised BUF_DEPTH FIFO of entry structs with push, pop, synchronous flush, count, and a head output. Flush overrides push.

Test Plan:
- Reset release, instr_ready=1: requests to 'o0200, 'o0201, 'o0202 in consecutive cycles. First instr_valid appears 2 cycles after the first request, with instr_pc='o0200 and data equal to what memory returned; then one instruction per cycle in order.
- instr_ready=0 from reset: exactly 2 requests issue, then ifu_rd_req stays 0 and the head ('o0200) holds. Raising ready delivers 'o0200, 'o0201, 'o0202… with no duplicates or gaps.
- redirect_pc='o7777: next requests are 'o7777 then 'o0000; instr_pc values follow the same wrap.
- Redirect to 'o4000 while a read is in flight and the buffer holds 1 entry: instr_valid=0 the next cycle, the stale response is never presented, and the next presented instr_pc='o4000.
- halt_req=1 with one read pending: DRAIN for 1 cycle, then ifu_halted=1 with no further requests, and buffered entries are still delivered. halt_req=0 resumes at the next sequential pc.
- rst_n=0 for 1 cycle with a full buffer and a pending read: next cycle instr_valid=0 and ifu_rd_req=0; fetch restarts at 'o0200.

Source files
------------

// File: rtl/ifu_pkg.sv
// Shared types for the instruction fetch unit.
//   - addr_t / word_t : PC and instruction word types
//   - RESET_PC        : PC loaded on reset
//   - ifu_state_e     : fetch control state
//   - ifu_entry_t     : instruction buffer entry {word, pc}
//   - addr_inc()      : sequential PC step, wraps at 2^ADDR_W
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 12
`endif
`ifndef DATA_WIDTH
`define DATA_WIDTH 12
`endif

package ifu_pkg;

    localparam int ADDR_W = `ADDR_WIDTH;
    localparam int DATA_W = `DATA_WIDTH;

    typedef logic [ADDR_W-1:0] addr_t;
    typedef logic [DATA_W-1:0] word_t;

    localparam addr_t RESET_PC = addr_t'(12'o0200);

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_DRAIN  = 2'd1,
        ST_HALTED = 2'd2
    } ifu_state_e;

    typedef struct packed {
        word_t word;
        addr_t pc;
    } ifu_entry_t;

    function automatic addr_t addr_inc(input addr_t a);
        return a + addr_t'(1'b1);
    endfunction

endpackage

// File: rtl/ifu_instr_fifo.sv
// Instruction buffer: DEPTH-entry FIFO of {word, pc} entries.
//   clk, rst_n   : clock, synchronous active-low reset
//   flush_i      : empty the FIFO at the next edge (overrides push)
//   push_i       : write push_entry_i at the tail
//   pop_i        : consume the head (ignored when empty)
//   count_o      : number of stored entries
//   valid_o      : head is valid (count_o != 0)
//   head_o       : head entry, zero when empty
module ifu_instr_fifo
    import ifu_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush_i,
    input  logic             push_i,
    input  ifu_entry_t       push_entry_i,
    input  logic             pop_i,
    output logic [CNT_W-1:0] count_o,
    output logic             valid_o,
    output ifu_entry_t       head_o
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
        if (p == PTR_W'(DEPTH - 1)) begin
            return '0;
        end else begin
            return p + PTR_W'(1'b1);
        end
    endfunction

    ifu_entry_t        mem_q [DEPTH];
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              do_pop_s;
    logic              do_push_s;

    // Pointer and occupancy update; a pop frees a slot for a same-cycle push.
    always_comb begin
        do_pop_s  = pop_i && (count_q != '0);
        do_push_s = push_i && ((count_q != CNT_W'(DEPTH)) || do_pop_s);
        rd_ptr_d  = rd_ptr_q;
        wr_ptr_d  = wr_ptr_q;
        count_d   = count_q;
        if (flush_i) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_pop_s) begin
                rd_ptr_d = ptr_next(rd_ptr_q);
            end else begin
                rd_ptr_d = rd_ptr_q;
            end
            if (do_push_s) begin
                wr_ptr_d = ptr_next(wr_ptr_q);
            end else begin
                wr_ptr_d = wr_ptr_q;
            end
            if (do_push_s && !do_pop_s) begin
                count_d = count_q + CNT_W'(1'b1);
            end else if (do_pop_s && !do_push_s) begin
                count_d = count_q - CNT_W'(1'b1);
            end else begin
                count_d = count_q;
            end
        end
    end

    // Pointer, count and storage registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
            if (do_push_s && !flush_i) begin
                mem_q[wr_ptr_q] <= push_entry_i;
            end
        end
    end

    assign count_o = count_q;
    assign valid_o = (count_q != '0);
    // Stale storage is masked so an empty buffer presents all-zero data.
    assign head_o  = valid_o ? mem_q[rd_ptr_q] : '0;

endmodule

// File: rtl/ifu_fetch.sv
// Instruction fetch unit: owns the PC, issues one-word reads to instruction
// memory (data returns the cycle after the request), buffers returned words
// with their addresses and hands them to decode over valid/ready.
//   clk, rst_n                 : clock, synchronous active-low reset
//   ifu_rd_req/ifu_rd_addr     : memory read request and address
//   ifu_rd_data                : memory read data, one cycle after request
//   instr_valid/data/pc        : buffer head presented to decode
//   instr_ready                : decode accepts the head this cycle
//   redirect_valid/redirect_pc : flush everything and restart at redirect_pc
//   halt_req                   : stop issuing new reads (level)
//   ifu_halted                 : fetch is quiesced
module ifu_fetch
    import ifu_pkg::*;
#(
    parameter int    ADDR_WIDTH = ifu_pkg::ADDR_W,
    parameter int    DATA_WIDTH = ifu_pkg::DATA_W,
    parameter addr_t RESET_PC   = ifu_pkg::RESET_PC,
    parameter int    BUF_DEPTH  = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    output logic                  ifu_rd_req,
    output logic [ADDR_WIDTH-1:0] ifu_rd_addr,
    input  logic [DATA_WIDTH-1:0] ifu_rd_data,
    output logic                  instr_valid,
    output logic [DATA_WIDTH-1:0] instr_data,
    output logic [ADDR_WIDTH-1:0] instr_pc,
    input  logic                  instr_ready,
    input  logic                  redirect_valid,
    input  logic [ADDR_WIDTH-1:0] redirect_pc,
    input  logic                  halt_req,
    output logic                  ifu_halted
);

    localparam int CNT_W = $clog2(BUF_DEPTH + 1);

    ifu_state_e       state_q, state_d;
    addr_t            pc_q, pc_d;
    addr_t            pend_addr_q, pend_addr_d;
    logic             pending_q, pending_d;
    // Low for the first cycle after reset so nothing is requested then.
    logic             live_q;

    logic [CNT_W-1:0] fifo_count_s;
    logic             fifo_valid_s;
    ifu_entry_t       fifo_head_s;
    ifu_entry_t       push_entry_s;
    logic             pop_s;
    logic             push_s;
    logic [CNT_W:0]   occupancy_s;
    logic             issue_s;

    ifu_instr_fifo #(
        .DEPTH (BUF_DEPTH),
        .CNT_W (CNT_W)
    ) u_fifo (
        .clk          (clk),
        .rst_n        (rst_n),
        .flush_i      (redirect_valid),
        .push_i       (push_s),
        .push_entry_i (push_entry_s),
        .pop_i        (pop_s),
        .count_o      (fifo_count_s),
        .valid_o      (fifo_valid_s),
        .head_o       (fifo_head_s)
    );

    // Issue decision: counting the in-flight word and this cycle's pop keeps
    // the buffer from ever overflowing while sustaining one word per cycle.
    always_comb begin
        pop_s        = fifo_valid_s && instr_ready;
        occupancy_s  = {1'b0, fifo_count_s} + {{CNT_W{1'b0}}, pending_q}
                       - {{CNT_W{1'b0}}, pop_s};
        issue_s      = live_q && (state_q == ST_RUN) && !halt_req &&
                       !redirect_valid && (occupancy_s < (CNT_W+1)'(BUF_DEPTH));
        push_s       = pending_q && !redirect_valid;
        push_entry_s = '{word: ifu_rd_data, pc: pend_addr_q};
    end

    // PC and in-flight tracking; a redirect overrides sequential fetch.
    always_comb begin
        pc_d        = pc_q;
        pend_addr_d = pend_addr_q;
        pending_d   = issue_s;
        if (redirect_valid) begin
            pc_d = redirect_pc;
        end else if (issue_s) begin
            pc_d = addr_inc(pc_q);
        end else begin
            pc_d = pc_q;
        end
        if (issue_s) begin
            pend_addr_d = pc_q;
        end else begin
            pend_addr_d = pend_addr_q;
        end
    end

    // Fetch control FSM next state; redirect always returns to RUN.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_RUN: begin
                if (halt_req) begin
                    state_d = pending_q ? ST_DRAIN : ST_HALTED;
                end else begin
                    state_d = ST_RUN;
                end
            end
            ST_DRAIN: begin
                // The outstanding word was pushed in the cycle that entered DRAIN.
                if (!pending_q) begin
                    state_d = ST_HALTED;
                end else begin
                    state_d = ST_DRAIN;
                end
            end
            ST_HALTED: begin
                if (!halt_req) begin
                    state_d = ST_RUN;
                end else begin
                    state_d = ST_HALTED;
                end
            end
            default: begin
                state_d = ST_RUN;
            end
        endcase
        if (redirect_valid) begin
            state_d = ST_RUN;
        end else begin
            state_d = state_d;
        end
    end

    // State registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= ST_RUN;
            pc_q        <= RESET_PC;
            pend_addr_q <= '0;
            pending_q   <= 1'b0;
            live_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            pend_addr_q <= pend_addr_d;
            pending_q   <= pending_d;
            live_q      <= 1'b1;
        end
    end

    assign ifu_rd_req  = issue_s;
    assign ifu_rd_addr = issue_s ? pc_q : '0;
    assign instr_valid = fifo_valid_s;
    assign instr_data  = fifo_head_s.word;
    assign instr_pc    = fifo_head_s.pc;
    assign ifu_halted  = (state_q == ST_HALTED);

endmodule

// File: tb/tb_ifu_fetch.sv
module tb_ifu_fetch;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        ifu_rd_req;
    logic [11:0] ifu_rd_addr;
    logic [11:0] ifu_rd_data;
    logic        instr_valid;
    logic [11:0] instr_data;
    logic [11:0] instr_pc;
    logic        instr_ready;
    logic        redirect_valid;
    logic [11:0] redirect_pc;
    logic        halt_req;
    logic        ifu_halted;

    int checks = 0;
    int errors = 0;

    ifu_fetch dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .ifu_rd_req     (ifu_rd_req),
        .ifu_rd_addr    (ifu_rd_addr),
        .ifu_rd_data    (ifu_rd_data),
        .instr_valid    (instr_valid),
        .instr_data     (instr_data),
        .instr_pc       (instr_pc),
        .instr_ready    (instr_ready),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .halt_req       (halt_req),
        .ifu_halted     (ifu_halted)
    );

    always #5 clk = ~clk;

    // Registered memory: word at address a is ~a; junk when no request.
    always @(posedge clk) begin
        ifu_rd_data <= ifu_rd_req ? ~ifu_rd_addr : 12'o1234;
    end

    typedef struct {
        logic        rst;
        logic        rdy;
        logic        halt;
        logic        rv;
        logic [11:0] rpc;
        logic        ereq;
        logic [11:0] eaddr;
        logic        evalid;
        logic [11:0] epc;
        logic        ehalt;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic rst, input logic rdy, input logic halt,
                       input logic rv, input logic [11:0] rpc,
                       input logic ereq, input logic [11:0] eaddr,
                       input logic evalid, input logic [11:0] epc,
                       input logic ehalt);
        vec_t v;
        v.rst = rst; v.rdy = rdy; v.halt = halt; v.rv = rv; v.rpc = rpc;
        v.ereq = ereq; v.eaddr = eaddr; v.evalid = evalid; v.epc = epc;
        v.ehalt = ehalt;
        vecs.push_back(v);
    endtask

    task automatic chk(input string nm, input int cyc,
                       input logic [11:0] act, input logic [11:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cycle %0d actual %o required %o", nm, cyc, act, exp);
        end
    endtask

    initial begin
        logic [11:0] exp_word;
        logic [11:0] req_addrs[$];
        logic [11:0] next_pc;
        int          delivered;
        int          budget;

        //   rst rdy hlt rv rpc       req addr      vld pc        hlt
        add(1, 1, 0, 0, 12'o0000,   0, 12'o0000,  0, 12'o0000,  0); // c0 post-reset bubble
        add(1, 1, 0, 0, 12'o0000,   1, 12'o0200,  0, 12'o0000,  0);
        add(1, 1, 0, 0, 12'o0000,   1, 12'o0201,  0, 12'o0000,  0);
        add(1, 1, 0, 0, 12'o0000,   1, 12'o0202,  1, 12'o0200,  0);
        add(1, 1, 0, 0, 12'o0000,   1, 12'o0203,  1, 12'o0201,  0);
        add(1, 1, 0, 0, 12'o0000,   1, 12'o0204,  1, 12'o0202,  0); // c5
        add(1, 0, 0, 0, 12'o0000,   0, 12'o0000,  1, 12'o0203,  0); // stall
        add(1, 0, 0, 0, 12'o0000,   0, 12'o0000,  1, 12'o0203,  0);
        add(1, 1, 0, 0, 12'o0000,   1, 12'o0205,  1, 12'o0203,  0);
        add(1, 1, 0, 0, 12'o0000,   1, 12'o0206,  1, 12'o0204,  0);
        add(1, 0, 0, 1, 12'o4000,   0, 12'o0000,  1, 12'o0205,  0); // c10 redirect
        add(1, 1, 0, 0, 12'o0000,   1, 12'o4000,  0, 12'o0000,  0);
        add(1, 1, 0, 0, 12'o0000,   1, 12'o4001,  0, 12'o0000,  0);
        add(1, 1, 0, 0, 12'o0000,   1, 12'o4002,  1, 12'o4000,  0);
        add(1, 1, 0, 1, 12'o7777,   0, 12'o0000,  1, 12'o4001,  0); // c14 redirect wrap
        add(1, 1, 0, 0, 12'o0000,   1, 12'o7777,  0, 12'o0000,  0);
        add(1, 1, 0, 0, 12'o0000,   1, 12'o0000,  0, 12'o0000,  0);
        add(1, 1, 0, 0, 12'o0000,   1, 12'o0001,  1, 12'o7777,  0);
        add(1, 1, 0, 0, 12'o0000,   1, 12'o0002,  1, 12'o0000,  0);
        add(1, 0, 1, 0, 12'o0000,   0, 12'o0000,  1, 12'o0001,  0); // c19 halt, pending
        add(1, 1, 1, 0, 12'o0000,   0, 12'o0000,  1, 12'o0001,  0); // DRAIN
        add(1, 1, 1, 0, 12'o0000,   0, 12'o0000,  1, 12'o0002,  1); // HALTED
        add(1, 1, 1, 0, 12'o0000,   0, 12'o0000,  0, 12'o0000,  1);
        add(1, 1, 0, 0, 12'o0000,   0, 12'o0000,  0, 12'o0000,  1); // release
        add(1, 1, 0, 0, 12'o0000,   1, 12'o0003,  0, 12'o0000,  0);
        add(1, 1, 0, 0, 12'o0000,   1, 12'o0004,  0, 12'o0000,  0); // c25
        add(1, 1, 0, 0, 12'o0000,   1, 12'o0005,  1, 12'o0003,  0);
        add(0, 0, 0, 0, 12'o0000,   0, 12'o0000,  1, 12'o0004,  0); // c27 reset
        add(1, 1, 0, 0, 12'o0000,   0, 12'o0000,  0, 12'o0000,  0);
        add(1, 1, 0, 0, 12'o0000,   1, 12'o0200,  0, 12'o0000,  0);
        add(1, 1, 0, 0, 12'o0000,   1, 12'o0201,  0, 12'o0000,  0); // c30
        add(1, 1, 0, 0, 12'o0000,   1, 12'o0202,  1, 12'o0200,  0);
        add(1, 1, 1, 0, 12'o0000,   0, 12'o0000,  1, 12'o0201,  0); // halt again
        add(1, 1, 1, 0, 12'o0000,   0, 12'o0000,  1, 12'o0202,  0); // DRAIN
        add(1, 1, 1, 1, 12'o5000,   0, 12'o0000,  0, 12'o0000,  1); // redirect from HALTED
        add(1, 1, 1, 0, 12'o0000,   0, 12'o0000,  0, 12'o0000,  0); // c35 RUN, halt re-seen
        add(1, 1, 0, 0, 12'o0000,   0, 12'o0000,  0, 12'o0000,  1);
        add(1, 1, 0, 0, 12'o0000,   1, 12'o5000,  0, 12'o0000,  0);
        add(1, 1, 0, 0, 12'o0000,   1, 12'o5001,  0, 12'o0000,  0);
        add(1, 1, 0, 0, 12'o0000,   1, 12'o5002,  1, 12'o5000,  0);

        rst_n          = 1'b0;
        instr_ready    = 1'b1;
        halt_req       = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 12'o0000;
        repeat (2) @(posedge clk);
        #1;

        for (int i = 0; i < vecs.size(); i++) begin
            rst_n          = vecs[i].rst;
            instr_ready    = vecs[i].rdy;
            halt_req       = vecs[i].halt;
            redirect_valid = vecs[i].rv;
            redirect_pc    = vecs[i].rpc;
            @(negedge clk);
            exp_word = vecs[i].evalid ? ~vecs[i].epc : 12'o0000;
            chk("rd_req",  i, {11'd0, ifu_rd_req},  {11'd0, vecs[i].ereq});
            chk("rd_addr", i, ifu_rd_addr,          vecs[i].eaddr);
            chk("valid",   i, {11'd0, instr_valid}, {11'd0, vecs[i].evalid});
            chk("pc",      i, instr_pc,             vecs[i].epc);
            chk("data",    i, instr_data,           exp_word);
            chk("halted",  i, {11'd0, ifu_halted},  {11'd0, vecs[i].ehalt});
            @(posedge clk);
            #1;
        end

        // Stalled decode from reset: exactly two reads, head holds at 'o0200.
        rst_n          = 1'b0;
        instr_ready    = 1'b0;
        halt_req       = 1'b0;
        redirect_valid = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            if (ifu_rd_req) begin
                req_addrs.push_back(ifu_rd_addr);
            end
            if (instr_valid) begin
                chk("stall_head", c, instr_pc, 12'o0200);
            end
            @(posedge clk);
            #1;
        end
        chk("stall_req_count", 0, 12'(req_addrs.size()), 12'd2);
        if (req_addrs.size() == 2) begin
            chk("stall_addr0", 0, req_addrs[0], 12'o0200);
            chk("stall_addr1", 1, req_addrs[1], 12'o0201);
        end
        chk("stall_valid", 0, {11'd0, instr_valid}, 12'd1);

        // Release: in-order delivery with no duplicates or gaps.
        instr_ready = 1'b1;
        next_pc     = 12'o0200;
        delivered   = 0;
        budget      = 0;
        while (delivered < 8 && budget < 40) begin
            @(negedge clk);
            if (instr_valid) begin
                chk("drain_pc",   delivered, instr_pc,   next_pc);
                chk("drain_data", delivered, instr_data, ~next_pc);
                next_pc   = next_pc + 12'd1;
                delivered = delivered + 1;
            end
            budget = budget + 1;
            @(posedge clk);
            #1;
        end
        chk("drain_delivered", 0, 12'(delivered), 12'd8);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
